// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory port arbiter:
//   own_t       - port owner (CPU load/store stage or secondary master)
//   DEF_MAXWAIT - default contended cycles before the secondary is forced in
//   DEF_BURST   - default maximum locked burst length
//   cnt_width() - width of the wait/beat counters for a given MAXWAIT/BURST
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_B = 1'b1
  } own_t;

  localparam int unsigned DEF_MAXWAIT = 4;
  localparam int unsigned DEF_BURST   = 4;

  // Wide enough to hold max(MAXWAIT, BURST).
  function automatic int unsigned cnt_width(input int unsigned maxwait,
                                            input int unsigned burst);
    int unsigned m;
    m = (maxwait > burst) ? maxwait : burst;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(DEF_MAXWAIT, DEF_BURST);

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones, with synchronous clear.
// Ports:
//   clk     - clock
//   i_clr   - synchronous clear (dominates i_en)
//   i_en    - count enable
//   o_count - current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the CPU memory stage (priority)
// and one secondary master (debug loader / DMA). The secondary master gets the
// port after at most MAXWAIT contended cycles and may lock bursts of up to
// BURST beats; the CPU is stalled while the secondary owns the port.
//
// Build option: DMEM_ARB_STATS_EN enables the saturating statistics counters
// (stat_bbeats, stat_cstalls); without it both outputs are tied to zero.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_din    - CPU access request
//   c_dout, c_stall            - CPU read data (combinational), stall
//   b_req/b_we/b_lock          - secondary request, write, keep grant
//   b_addr/b_din               - secondary address / write data
//   b_gnt                      - secondary owns the port this cycle
//   b_rdata, b_rvalid          - registered secondary read data / strobe
//   m_addr/m_din/m_we, m_dout  - memory / IO port
//   stat_bbeats, stat_cstalls  - statistics counters
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DBITS   = 16,
  parameter int unsigned MAXWAIT = DEF_MAXWAIT,
  parameter int unsigned BURST   = DEF_BURST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [DBITS-1:0] c_addr,
  input  logic [DBITS-1:0] c_din,
  output logic [DBITS-1:0] c_dout,
  output logic             c_stall,
  input  logic             b_req,
  input  logic             b_we,
  input  logic             b_lock,
  input  logic [DBITS-1:0] b_addr,
  input  logic [DBITS-1:0] b_din,
  output logic             b_gnt,
  output logic [DBITS-1:0] b_rdata,
  output logic             b_rvalid,
  output logic [DBITS-1:0] m_addr,
  output logic [DBITS-1:0] m_din,
  output logic             m_we,
  input  logic [DBITS-1:0] m_dout,
  output logic [15:0]      stat_bbeats,
  output logic [15:0]      stat_cstalls
);

  localparam int unsigned   CW        = cnt_width(MAXWAIT, BURST);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAXWAIT - 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  own_t             r_own;
  logic [CW-1:0]    r_waitcnt;
  logic [CW-1:0]    r_beatcnt;
  logic             r_rvalid;
  logic [DBITS-1:0] r_rdata;

  logic             w_own_b;
  logic             w_b_read;

  // Port mux. A secondary write is suppressed in a reset cycle so an
  // abandoned burst never lands a beat.
  always_comb begin
    w_own_b  = (r_own == OWN_B);
    w_b_read = w_own_b & b_req & ~b_we;
    b_gnt    = w_own_b;
    c_stall  = w_own_b & c_req;
    if (w_own_b) begin
      m_addr = b_addr;
      m_din  = b_din;
      m_we   = b_req & b_we & ~reset;
    end else begin
      m_addr = c_addr;
      m_din  = c_din;
      m_we   = c_req & c_we;
    end
  end

  assign c_dout   = m_dout;
  assign b_rdata  = r_rdata;
  assign b_rvalid = r_rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_own     <= OWN_C;
      r_waitcnt <= '0;
      r_beatcnt <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_rvalid <= 1'b0;
      case (r_own)
        OWN_C: begin
          r_beatcnt <= '0;
          if (b_req && !c_req) begin
            r_own     <= OWN_B;
            r_waitcnt <= '0;
          end else if (b_req && c_req) begin
            if (r_waitcnt == WAIT_LAST) begin
              r_own     <= OWN_B;
              r_waitcnt <= '0;
            end else begin
              r_waitcnt <= r_waitcnt + CNT_ONE;
            end
          end else begin
            r_waitcnt <= '0;
          end
        end
        OWN_B: begin
          r_waitcnt <= '0;
          if (w_b_read) begin
            r_rdata  <= m_dout;
            r_rvalid <= 1'b1;
          end
          // Leaving always passes through OWN_C, giving the CPU at least one
          // cycle between bursts.
          if (b_req && b_lock && (r_beatcnt < BEAT_LAST)) begin
            r_beatcnt <= r_beatcnt + CNT_ONE;
          end else begin
            r_own     <= OWN_C;
            r_beatcnt <= '0;
          end
        end
        default: r_own <= OWN_C;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic w_beat_en;
  logic w_stall_en;

  assign w_beat_en  = w_own_b & b_req;
  assign w_stall_en = c_stall;

  sat_counter #(.WIDTH(16)) u_stat_bbeats (
    .clk     (clk),
    .i_clr   (reset),
    .i_en    (w_beat_en),
    .o_count (stat_bbeats)
  );

  sat_counter #(.WIDTH(16)) u_stat_cstalls (
    .clk     (clk),
    .i_clr   (reset),
    .i_en    (w_stall_en),
    .o_count (stat_cstalls)
  );
`else
  assign stat_bbeats  = '0;
  assign stat_cstalls = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed scenarios followed by randomized traffic, checked every cycle
// against a history-based reference model of the arbitration rules and a
// shadow copy of memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int unsigned MAXWAIT = 4;
  localparam int unsigned BURST   = 4;
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, c_req, c_we, b_req, b_we, b_lock;
  logic [15:0] c_addr, c_din, b_addr, b_din;
  logic [15:0] c_dout, b_rdata, m_addr, m_din, m_dout;
  logic [15:0] stat_bbeats, stat_cstalls;
  logic        c_stall, b_gnt, b_rvalid, m_we;

  dmem_arbiter #(.DBITS(16), .MAXWAIT(MAXWAIT), .BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_din(c_din),
    .c_dout(c_dout), .c_stall(c_stall),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_din(b_din),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .m_addr(m_addr), .m_din(m_din), .m_we(m_we), .m_dout(m_dout),
    .stat_bbeats(stat_bbeats), .stat_cstalls(stat_cstalls)
  );

  // Memory behind the port: combinational read, write at the clock edge.
  logic [15:0] mem [0:1023];
  assign m_dout = mem[m_addr[10:1]];
  always @(posedge clk) if (m_we) mem[m_addr[10:1]] <= m_din;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [15:0] a);
    return {22'd0, a[10:1]};
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    return 16'h0200 | {11'd0, r, 1'b0};
  endfunction

  // Reference model: grant decided from counts of recent history.
  logic [15:0] shadow [0:1023];
  bit          exp_gnt   = 1'b0;
  int unsigned wait_run  = 0;   // consecutive contended, ungranted cycles
  int unsigned beat_run  = 0;   // consecutive granted cycles
  bit          exp_rv    = 1'b0;
  logic [15:0] exp_rd    = '0;
  int unsigned exp_beats = 0;
  int unsigned exp_stalls = 0;
  bit          obs_gnt, obs_stall;
  logic [7:0]  gnt_hist;

  // One clock cycle with the currently driven inputs; entered and left at
  // posedge + 1.
  task automatic step();
    logic        e_we;
    logic [15:0] e_addr, e_din;
    bit          nxt, nv;
    @(negedge clk);
    e_addr = exp_gnt ? b_addr : c_addr;
    e_din  = exp_gnt ? b_din  : c_din;
    e_we   = exp_gnt ? (b_req & b_we & ~reset) : (c_req & c_we);
    check_eq("b_gnt", b_gnt, exp_gnt);
    check_eq("c_stall", c_stall, c_req & exp_gnt);
    check_eq("m_we", m_we, e_we);
    check_eq("m_addr", m_addr, e_addr);
    if (e_we) check_eq("m_din", m_din, e_din);
    check_eq("c_dout", c_dout, shadow[widx(e_addr)]);
    check_eq("b_rvalid", b_rvalid, exp_rv);
    check_eq("b_rdata", b_rdata, exp_rd);
    check_eq("stat_bbeats", stat_bbeats, STATS ? exp_beats : 0);
    check_eq("stat_cstalls", stat_cstalls, STATS ? exp_stalls : 0);
    obs_gnt   = b_gnt;
    obs_stall = c_stall;
    gnt_hist  = {gnt_hist[6:0], b_gnt};

    if (exp_gnt && b_req && exp_beats < 65535) exp_beats++;
    if (exp_gnt && c_req && exp_stalls < 65535) exp_stalls++;
    nv = 1'b0;
    if (exp_gnt) begin
      if (b_req && !reset) begin
        if (b_we) shadow[widx(b_addr)] = b_din;
        else begin
          nv     = 1'b1;
          exp_rd = shadow[widx(b_addr)];
        end
      end
      beat_run++;
      nxt      = b_req && b_lock && (beat_run < BURST);
      wait_run = 0;
    end else begin
      if (c_req && c_we) shadow[widx(c_addr)] = c_din;
      if (b_req && c_req) wait_run++;
      nxt = b_req && (!c_req || wait_run >= MAXWAIT);
      if (nxt || !b_req) wait_run = 0;
    end
    if (!nxt) beat_run = 0;
    exp_gnt = nxt;
    exp_rv  = nv;
    if (reset) begin
      exp_gnt = 1'b0; wait_run = 0; beat_run = 0; exp_rv = 1'b0;
      exp_rd = '0; exp_beats = 0; exp_stalls = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          k, cyc;
    logic [15:0] a, orig;

    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 16'(i * 37 + 5);
      shadow[i] = 16'(i * 37 + 5);
    end
    mem[16'h0400 >> 1]    = 16'h1234;
    shadow[16'h0400 >> 1] = 16'h1234;

    reset = 1'b1; c_req = 0; c_we = 0; c_addr = '0; c_din = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_din = '0;
    gnt_hist = '0;
    @(posedge clk);
    #1;
    step();
    check_eq("rst_gnt", b_gnt, 0);
    check_eq("rst_stall", c_stall, 0);
    check_eq("rst_rvalid", b_rvalid, 0);
    reset = 1'b0;

    // Uncontended secondary read.
    b_req = 1; b_we = 0; b_addr = 16'h0400; b_lock = 0;
    step();
    check_eq("rd_gnt", b_gnt, 1);
    step();
    b_req = 0;
    check_eq("rd_rvalid", b_rvalid, 1);
    check_eq("rd_rdata", b_rdata, 16'h1234);
    check_eq("rd_stall", c_stall, 0);
    step();

    // Contention with continuous CPU traffic.
    pulse_reset();
    c_req = 1; c_we = 0; c_addr = 16'h0010;
    b_req = 1; b_we = 0; b_addr = 16'h0020; b_lock = 0;
    for (int i = 0; i < 4; i++) begin
      check_eq("cont_wait", b_gnt, 0);
      step();
    end
    check_eq("cont_gnt", b_gnt, 1);
    check_eq("cont_stall", c_stall, 1);
    step();
    b_req = 0;
    check_eq("cont_cpu_go", c_stall, 0);
    step();
    c_req = 0;
`ifdef DMEM_ARB_STATS_EN
    check_eq("cont_stat_cstalls", stat_cstalls, 1);
    check_eq("cont_stat_bbeats", stat_bbeats, 1);
`endif

    // Locked 6-beat write burst, CPU idle.
    pulse_reset();
    gnt_hist = '0;
    k = 0; cyc = 0;
    while (k < 6 && cyc < 20) begin
      b_req = 1; b_we = 1; b_addr = 16'h0300 + 16'(2 * k);
      b_din = 16'hB000 + 16'(k); b_lock = (k < 5);
      step();
      if (obs_gnt) k++;
      cyc++;
    end
    b_req = 0; b_lock = 0;
    check_eq("burst_beats", k, 6);
    check_eq("burst_pattern", gnt_hist, 8'b0111_1011);
    for (int i = 0; i < 6; i++) begin
      a = 16'h0300 + 16'(2 * i);
      check_eq("burst_mem", mem[widx(a)], 16'hB000 + 16'(i));
    end

    // Simultaneous writes while the secondary owns the port.
    pulse_reset();
    b_req = 1; b_we = 1; b_addr = 16'h0100; b_din = 16'h5555; b_lock = 0;
    step();
    check_eq("coll_gnt", b_gnt, 1);
    c_req = 1; c_we = 1; c_addr = 16'h0100; c_din = 16'hAAAA;
    step();
    b_req = 0;
    check_eq("coll_first", mem[widx(16'h0100)], 16'h5555);
    step();
    c_req = 0; c_we = 0;
    check_eq("coll_retry", mem[widx(16'h0100)], 16'hAAAA);

    // Reset during the second beat of a burst.
    pulse_reset();
    orig = mem[widx(16'h0342)];
    b_req = 1; b_we = 1; b_lock = 1; b_addr = 16'h0340; b_din = 16'hC001;
    step();
    step();
    b_addr = 16'h0342; b_din = 16'hC002; reset = 1;
    #1;
    check_eq("rmb_we_in_reset", m_we, 0);
    step();
    reset = 0;
    check_eq("rmb_gnt", b_gnt, 0);
    check_eq("rmb_rvalid", b_rvalid, 0);
    check_eq("rmb_we", m_we, 0);
    b_req = 0; b_lock = 0;
    step();
    check_eq("rmb_nowrite", mem[widx(16'h0342)], orig);

`ifdef DMEM_ARB_STATS_EN
    // Drive the stall counter past its saturation point.
    pulse_reset();
    b_req = 1; b_we = 0; b_addr = 16'h0200; b_lock = 1; c_we = 0; c_addr = 16'h0210;
    for (int i = 0; i < 82600; i++) begin
      c_req = b_gnt;
      step();
    end
    b_req = 0; b_lock = 0; c_req = 0;
    check_eq("sat_cstalls", stat_cstalls, 16'hFFFF);
`endif

    // Randomized traffic; both masters hold a request until it is served.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!(c_req && obs_stall)) begin
        c_req  = ($urandom_range(0, 99) < 60);
        c_we   = 1'($urandom_range(0, 1));
        c_addr = rand_addr();
        c_din  = 16'($urandom);
      end
      if (!(b_req && !obs_gnt)) begin
        b_req  = ($urandom_range(0, 99) < 45);
        b_we   = 1'($urandom_range(0, 1));
        b_addr = rand_addr();
        b_din  = 16'($urandom);
      end
      b_lock = 1'($urandom_range(0, 1));
      reset  = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
